lfsr_counter_ud: RTL and testbench
==================================

Name: lfsr_counter_ud

Overview:
Parametrised LFSR pseudorandom counter. It uses an XNOR Fibonacci structure with a programmable polynomial, and it can step forward or backward. It supports synchronous load, terminal-count detection and optional auto-reload on terminal count. It serves as the next-generation pseudorandom counter and sequence generator for scramblers, PN sources and timers where a binary counter's carry chain is too slow.

Parameters:
WIDTH, 12, counter width in bits; legal range 2..64.
POLY, 12'b0000_1001_1001, tap mask. Bit i=1 includes state bit i in the feedback. Bit 0 is always included, whatever POLY[0] holds. Bits at WIDTH and above are ignored.

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous reset, active-high
cen  input  1  count enable; steps the LFSR when high
dir  input  1  step direction: 0 = forward, 1 = backward
load  input  1  synchronous load of data, active-high
data  input  WIDTH  load / reload value
tc_value  input  WIDTH  terminal-count compare value
auto_reload  input  1  when high, reaching tc_value with cen reloads data instead of stepping
count  output  WIDTH  current LFSR state (registered)
tc  output  1  registered; high while count == tc_value
wrap  output  1  registered one-cycle pulse when an auto-reload occurred
lockup  output  1  high while count is all-ones (the XNOR lockup state)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - count = 0
  - tc = (tc_value == 0), evaluated on the reset cycle
  - wrap = 0
  - lockup = 0
- Reset mid-operation overrides everything on that edge.
- Feedback term: f = count[0] XOR (XOR over i=1..WIDTH-1 of POLY[i] & count[i]).
- Forward step: next = {~f, count[WIDTH-1:1]}. This is a shift toward the LSB with XNOR feedback into the MSB.
- Backward step, the exact inverse of forward:
  - next[WIDTH-1:1] = count[WIDTH-2:0]
  - next[0] = ~count[WIDTH-1] XOR (XOR over i=1..WIDTH-1 of POLY[i] & count[i-1])
  - A forward step followed by a backward step returns the original state.
- Priority per edge, highest first:
  1. reset
  2. load: count <= data, regardless of cen, dir or auto_reload
  3. cen && auto_reload && count == tc_value: count <= data; wrap <= 1
  4. cen: step in the direction given by dir
  5. otherwise hold
- wrap is 0 on every edge where case 3 does not apply.
- tc is recomputed every edge as (next count == tc_value sampled that edge). tc is therefore aligned with count. A change on tc_value alone is reflected one cycle later.
- lockup is registered as (next count == all-ones).
- With a primitive POLY, all-ones is a fixed point in both directions, and the period over the other 2^WIDTH - 1 states is 2^WIDTH - 1.
- A load of all-ones is legal and enters lockup.
- cen = 0 freezes count, tc and lockup, but wrap still clears.
- Latency: state change is visible on count one cycle after the enabling edge; there is no combinational path from inputs to outputs.

Optional Feature:
Macro: LFSR_LOCKUP_RECOVER_EN.
- Defined:
  - While count is all-ones, a cen step in either direction forces count <= 0 instead of the normal next value.
  - Sticky output lockup_err (1 bit, extra port) sets on that recovery edge. It clears only on reset or load.
  - Load and auto-reload priority are unchanged.
- Undefined:
  - lockup_err does not exist, and all-ones stays locked until load or reset.
  - lockup still reports the state.

Test Plan:
1. WIDTH=4, POLY=4'b0011, reset, then cen=1, dir=0 for 6 cycles -> count = 0, 8, C, E, 7, B; after 15 steps count returns to 0, with all 15 non-F states seen exactly once.
2. From count=8, cen=1, dir=1 -> count=0. Then run 20 random forward/backward steps and verify against a reference model; forward then backward is the identity.
3. WIDTH=4, tc_value=E, auto_reload=1, data=7, stepping from 0 -> sequence 8, C, E (tc=1), then 7 with wrap=1 for one cycle and tc=0.
4. load=1, data=F with cen=1 and dir=0 -> count=F, lockup=1.
   - Without the macro: the next cen step keeps F.
   - With LFSR_LOCKUP_RECOVER_EN: the next step gives count=0, lockup=0, lockup_err=1, and lockup_err holds until load.
5. Simultaneous load=1, cen=1, auto_reload=1, count==tc_value, data=3 -> count=3, wrap=0. Then assert reset mid-sequence -> count=0, wrap=0 on the next edge.
6. Default WIDTH=12, POLY -> run 4095 forward steps from 0 and verify return to 0 with no repeated state; cen=0 for 5 cycles holds count and tc.

Source files
------------

// File: rtl/lfsr_counter_ud.sv
// lfsr_counter_ud: parametrised up/down XNOR Fibonacci LFSR counter with
// synchronous load, terminal-count detection and optional auto-reload.
// Optional build macro LFSR_LOCKUP_RECOVER_EN: a step taken from the all-ones
// lockup state forces count to zero and sets the sticky lockup_err output.
module lfsr_counter_ud #(
  parameter int          WIDTH = 12,
  // Tap mask; bit 0 is always in the feedback, bits at WIDTH and above unused.
  parameter logic [63:0] POLY  = 64'(12'b0000_1001_1001)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cen,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] tc_value,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
`ifdef LFSR_LOCKUP_RECOVER_EN
  output logic             lockup_err,
`endif
  output logic             lockup
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic             fwd_fb;
  logic             bwd_fb;
  logic [WIDTH-1:0] step_fwd;
  logic [WIDTH-1:0] step_bwd;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
`ifdef LFSR_LOCKUP_RECOVER_EN
  logic             err_nxt;
`endif

  // Feedback for both directions; the backward step is the exact inverse of
  // the forward step, so it re-derives the bit that fell off the LSB.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    fwd_fb = count[0];
    bwd_fb = ~count[WIDTH-1];
    for (int i = 1; i < WIDTH; i++) begin
      if (POLY[i]) begin
        fwd_fb = fwd_fb ^ count[i];
        bwd_fb = bwd_fb ^ count[i-1];
      end
    end
    step_fwd = {~fwd_fb, count[WIDTH-1:1]};
    step_bwd = {count[WIDTH-2:0], bwd_fb};
  end

  // Next-state selection: load, then auto-reload on terminal count, then step.
  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
    err_nxt   = lockup_err;
`endif
    if (load) begin
      count_nxt = data;
`ifdef LFSR_LOCKUP_RECOVER_EN
      err_nxt   = 1'b0;
`endif
    end else if (cen && auto_reload && (count == tc_value)) begin
      count_nxt = data;
      wrap_nxt  = 1'b1;
    end else if (cen) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
      if (count == ALL_ONES) begin
        count_nxt = '0;
        err_nxt   = 1'b1;
      end else begin
        count_nxt = dir ? step_bwd : step_fwd;
      end
`else
      count_nxt = dir ? step_bwd : step_fwd;
`endif
    end
  end

  // State and status registers; flags are derived from the next count so
  // they stay aligned with count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      count      <= '0;
      tc         <= (tc_value == '0);
      wrap       <= 1'b0;
      lockup     <= 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
      lockup_err <= 1'b0;
`endif
    end else begin
      count      <= count_nxt;
      tc         <= (count_nxt == tc_value);
      wrap       <= wrap_nxt;
      lockup     <= (count_nxt == ALL_ONES);
`ifdef LFSR_LOCKUP_RECOVER_EN
      lockup_err <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_lfsr_counter_ud.sv
// tb_lfsr_counter_ud: directed bench for lfsr_counter_ud with a 4-bit
// (POLY 4'b0011) instance and a default 12-bit instance.
module tb_lfsr_counter_ud;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic       reset = 1'b1;
  // 4-bit instance
  logic       s_cen = 0, s_dir = 0, s_load = 0, s_ar = 0;
  logic [3:0] s_data = '0, s_tcv = '0, s_count;
  logic       s_tc, s_wrap, s_lockup;
  // 12-bit instance
  logic        l_cen = 0, l_dir = 0, l_load = 0, l_ar = 0;
  logic [11:0] l_data = '0, l_tcv = 12'h800, l_count;
  logic        l_tc, l_wrap, l_lockup;
`ifdef LFSR_LOCKUP_RECOVER_EN
  logic        s_err, l_err;
`endif

  lfsr_counter_ud #(.WIDTH(4), .POLY(64'h3)) u_small (
    .clk(clk), .reset(reset), .cen(s_cen), .dir(s_dir), .load(s_load),
    .data(s_data), .tc_value(s_tcv), .auto_reload(s_ar),
    .count(s_count), .tc(s_tc), .wrap(s_wrap),
`ifdef LFSR_LOCKUP_RECOVER_EN
    .lockup_err(s_err),
`endif
    .lockup(s_lockup)
  );

  lfsr_counter_ud u_large (
    .clk(clk), .reset(reset), .cen(l_cen), .dir(l_dir), .load(l_load),
    .data(l_data), .tc_value(l_tcv), .auto_reload(l_ar),
    .count(l_count), .tc(l_tc), .wrap(l_wrap),
`ifdef LFSR_LOCKUP_RECOVER_EN
    .lockup_err(l_err),
`endif
    .lockup(l_lockup)
  );

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference steps for WIDTH=4, POLY=4'b0011 (taps on bits 0 and 1).
  function automatic logic [3:0] fwd4(input logic [3:0] x);
    return {~(x[0] ^ x[1]), x[3:1]};
  endfunction
  function automatic logic [3:0] bwd4(input logic [3:0] x);
    return {x[2:0], ~x[3] ^ x[0]};
  endfunction

  initial begin
    logic [3:0]  exp1 [5];
    logic [15:0] seen4;
    logic [3:0]  m, saved;
    bit          seen12 [4096];
    int          reps;

    exp1 = '{4'h8, 4'hC, 4'hE, 4'h7, 4'hB};

    // Reset state with tc_value == 0 -> tc high.
    reset = 1'b1;
    tick();
    check("rst_count", s_count, 0);
    check("rst_tc", s_tc, 1);
    check("rst_wrap", s_wrap, 0);
    check("rst_lockup", s_lockup, 0);
    check("rst_l_tc", l_tc, 0);
    reset = 1'b0;

    // 1: full forward period over the 15 non-F states.
    s_cen = 1'b1; s_dir = 1'b0;
    seen4 = 16'h0001;
    reps  = 0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (n < 5) check($sformatf("fwd_seq%0d", n), s_count, exp1[n]);
      if (n < 14) begin
        if (seen4[s_count]) reps++;
        seen4[s_count] = 1'b1;
      end
    end
    check("period4_back_to_0", s_count, 0);
    check("period4_states", seen4, 16'h7FFF);
    check("period4_repeats", reps, 0);
    check("period4_tc", s_tc, 1);

    // 2: backward step from 8 gives 0, then random walk against the model.
    tick();
    check("fwd_to_8", s_count, 4'h8);
    s_dir = 1'b1;
    tick();
    check("bwd_8_to_0", s_count, 4'h0);
    m = 4'h0;
    for (int n = 0; n < 20; n++) begin
      s_dir = 1'($urandom_range(1, 0));
      m = s_dir ? bwd4(m) : fwd4(m);
      tick();
      check($sformatf("walk%0d", n), s_count, m);
    end
    saved = s_count;
    s_dir = 1'b0;
    tick();
    s_dir = 1'b1;
    tick();
    check("fwd_bwd_identity", s_count, saved);

    // 3: auto-reload at tc_value=E with data=7.
    reset = 1'b1; s_tcv = 4'hE; s_ar = 1'b1; s_data = 4'h7; s_dir = 1'b0;
    tick();
    reset = 1'b0;
    check("ar_rst_tc", s_tc, 0);
    tick(); check("ar_8", s_count, 4'h8);
    tick(); check("ar_C", s_count, 4'hC);
    tick(); check("ar_E", s_count, 4'hE);
    check("ar_E_tc", s_tc, 1);
    check("ar_E_wrap", s_wrap, 0);
    tick(); check("ar_reload", s_count, 4'h7);
    check("ar_wrap", s_wrap, 1);
    check("ar_reload_tc", s_tc, 0);
    tick(); check("ar_after", s_count, 4'hB);
    check("ar_wrap_clr", s_wrap, 0);

    // 4: load all-ones enters lockup.
    s_ar = 1'b0; s_load = 1'b1; s_data = 4'hF;
    tick();
    s_load = 1'b0;
    check("lock_count", s_count, 4'hF);
    check("lock_flag", s_lockup, 1);
`ifdef LFSR_LOCKUP_RECOVER_EN
    check("lock_err0", s_err, 0);
    tick();
    check("recover_count", s_count, 4'h0);
    check("recover_lockup", s_lockup, 0);
    check("recover_err", s_err, 1);
    tick();
    check("recover_step", s_count, 4'h8);
    check("err_sticky", s_err, 1);
`else
    tick();
    check("lock_hold_fwd", s_count, 4'hF);
    check("lock_hold_flag", s_lockup, 1);
    s_dir = 1'b1;
    tick();
    check("lock_hold_bwd", s_count, 4'hF);
    s_dir = 1'b0;
`endif
    s_load = 1'b1; s_data = 4'h3; s_tcv = 4'h3;
    tick();
    s_load = 1'b0;
    check("load3", s_count, 4'h3);
    check("load3_lockup", s_lockup, 0);
    check("load3_tc", s_tc, 1);
`ifdef LFSR_LOCKUP_RECOVER_EN
    check("err_clr_load", s_err, 0);
`endif

    // 5: load beats auto-reload; then a real reload, freeze, and mid reset.
    s_load = 1'b1; s_ar = 1'b1; s_cen = 1'b1;
    tick();
    s_load = 1'b0;
    check("load_prio_count", s_count, 4'h3);
    check("load_prio_wrap", s_wrap, 0);
    tick();
    check("reload3_count", s_count, 4'h3);
    check("reload3_wrap", s_wrap, 1);
    s_cen = 1'b0;
    tick();
    check("freeze_count", s_count, 4'h3);
    check("freeze_wrap_clr", s_wrap, 0);
    check("freeze_tc", s_tc, 1);
    s_cen = 1'b1; s_ar = 1'b0;
    tick();
    check("step_3_to_9", s_count, 4'h9);
    reset = 1'b1; s_load = 1'b1; s_data = 4'h5; s_ar = 1'b1;
    tick();
    reset = 1'b0; s_load = 1'b0;
    check("midrst_count", s_count, 0);
    check("midrst_wrap", s_wrap, 0);
    check("midrst_tc", s_tc, 0);
    s_cen = 1'b0;

    // 6: default 12-bit instance runs its full 4095-state period.
    l_cen = 1'b1;
    reps  = 0;
    seen12[0] = 1'b1;
    for (int n = 0; n < 4095; n++) begin
      tick();
      if (n == 0) begin
        check("l_first", l_count, 12'h800);
        check("l_first_tc", l_tc, 1);
      end
      if (n == 1) check("l_second", l_count, 12'hC00);
      if (n < 4094) begin
        if (seen12[l_count]) reps++;
        seen12[l_count] = 1'b1;
      end
    end
    check("l_period_back_to_0", l_count, 0);
    check("l_period_repeats", reps, 0);
    check("l_lockup", l_lockup, 0);
    tick();
    l_cen = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      check($sformatf("l_hold_count%0d", n), l_count, 12'h800);
      check($sformatf("l_hold_tc%0d", n), l_tc, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
